// File: rtl/fm_discriminator_if.sv
// Avalon-ST style I/Q sink and phase-difference source for the FM discriminator.
interface fm_discriminator_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] ast_sink_i;
  logic signed [DATA_WIDTH-1:0] ast_sink_q;
  logic                         ast_sink_valid;
  logic [1:0]                   ast_sink_error;
  logic signed [DATA_WIDTH-1:0] ast_source_data;
  logic                         ast_source_valid;
  logic [1:0]                   ast_source_error;

  modport master (
    output ast_sink_i, ast_sink_q, ast_sink_valid, ast_sink_error,
    input  ast_source_data, ast_source_valid, ast_source_error
  );

  modport slave (
    input  ast_sink_i, ast_sink_q, ast_sink_valid, ast_sink_error,
    output ast_source_data, ast_source_valid, ast_source_error
  );
endinterface

// File: rtl/fm_discriminator.sv
// FM discriminator: iterative vectoring CORDIC for atan2(Q, I), then the
// modulo-2^16 difference from the previous sample's phase.
module fm_discriminator #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ITERATIONS = 14
) (
  input logic              clk,
  input logic              reset_n,
  fm_discriminator_if.slave bus
);

  localparam int unsigned XW = DATA_WIDTH + 2;
  localparam int unsigned AW = 16;
  localparam int unsigned KW = 4;

  typedef enum logic [1:0] {
    IDLE,
    ROT,
    OUT
  } state_t;

  state_t                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic signed [XW-1:0]  x_q, x_d;
  logic signed [XW-1:0]  y_q, y_d;
  logic [AW-1:0]         z_q, z_d;
  logic [AW-1:0]         prev_q, prev_d;
  logic                  overrun_q, overrun_d;
  logic [1:0]            err_acc_q, err_acc_d;
  logic signed [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [1:0]            error_q, error_d;

  logic signed [XW-1:0]  x_shr_c;
  logic signed [XW-1:0]  y_shr_c;
  logic [AW-1:0]         atan_c;

  // atan(2^-k) with full scale 2^16 = 2*pi
  function automatic logic [AW-1:0] atan_lut(input logic [KW-1:0] k);
    logic [AW-1:0] a;
    case (k)
      4'd0:    a = 16'd8192;
      4'd1:    a = 16'd4836;
      4'd2:    a = 16'd2555;
      4'd3:    a = 16'd1297;
      4'd4:    a = 16'd651;
      4'd5:    a = 16'd326;
      4'd6:    a = 16'd163;
      4'd7:    a = 16'd81;
      4'd8:    a = 16'd41;
      4'd9:    a = 16'd20;
      4'd10:   a = 16'd10;
      4'd11:   a = 16'd5;
      4'd12:   a = 16'd3;
      4'd13:   a = 16'd1;
      default: a = 16'd0;
    endcase
    return a;
  endfunction

  assign x_shr_c = x_q >>> k_q;
  assign y_shr_c = y_q >>> k_q;
  assign atan_c  = atan_lut(k_q);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      prev_q    <= '0;
      overrun_q <= 1'b0;
      err_acc_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      prev_q    <= prev_d;
      overrun_q <= overrun_d;
      err_acc_q <= err_acc_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
    end
  end

  // Next-state, CORDIC step and output logic
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    prev_d    = prev_q;
    overrun_d = overrun_q;
    err_acc_d = err_acc_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    error_d   = error_q;

    case (state_q)
      IDLE: begin
        if (bus.ast_sink_valid) begin
          state_d   = ROT;
          k_d       = '0;
          err_acc_d = err_acc_q | bus.ast_sink_error;
          // Left half-plane is folded into the right by a pi pre-rotation
          if (bus.ast_sink_i[DATA_WIDTH-1]) begin
            x_d = -XW'(bus.ast_sink_i);
            y_d = -XW'(bus.ast_sink_q);
            z_d = 16'h8000;
          end else begin
            x_d = XW'(bus.ast_sink_i);
            y_d = XW'(bus.ast_sink_q);
            z_d = '0;
          end
        end
      end

      ROT: begin
        if (bus.ast_sink_valid) begin
          overrun_d = 1'b1;
        end
        if (!y_q[XW-1]) begin
          x_d = x_q + y_shr_c;
          y_d = y_q - x_shr_c;
          z_d = z_q + atan_c;
        end else begin
          x_d = x_q - y_shr_c;
          y_d = y_q + x_shr_c;
          z_d = z_q - atan_c;
        end
        k_d = k_q + KW'(1);
        if (k_q == KW'(ITERATIONS - 1)) begin
          state_d = OUT;
        end
      end

      OUT: begin
        // Modulo-2^16 subtraction performs the phase unwrap
        data_d    = DATA_WIDTH'(z_q - prev_q);
        prev_d    = z_q;
        valid_d   = 1'b1;
        error_d   = {|err_acc_q, overrun_q};
        err_acc_d = '0;
        overrun_d = bus.ast_sink_valid;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.ast_source_data  = data_q;
  assign bus.ast_source_valid = valid_q;
  assign bus.ast_source_error = error_q;

endmodule

// File: tb/tb_fm_discriminator.sv
// Scoreboard bench for fm_discriminator: ideal atan2 reference, queued
// expectations, independent output monitor.
module tb_fm_discriminator;

  localparam int  DW      = 16;
  localparam int  ITER    = 14;
  localparam int  LAT     = ITER + 1;
  localparam int  GAP_MIN = ITER + 2;
  localparam real PI      = 3.14159265358979;

  typedef struct {
    int         data;
    logic [1:0] err;
    int         cyc;
    int         tol;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  fm_discriminator_if #(.DATA_WIDTH(DW)) bus();

  fm_discriminator #(.DATA_WIDTH(DW), .ITERATIONS(ITER)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   n_out = 0;
  int   prev_ideal = 0;
  int   last_acc = -1000;
  int   cur_tol = 6;
  bit   pend_ovr = 1'b0;
  bit   prev_valid = 1'b0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ideal_phase(int i, int q);
    real a;
    a = $atan2(real'(q), real'(i));
    return int'(a * 32768.0 / PI) & 32'hFFFF;
  endfunction

  function automatic int wrap16(int v);
    int d;
    d = v & 32'hFFFF;
    if (d >= 32768) d = d - 65536;
    return d;
  endfunction

  task automatic check(string name, int act, int exp, int tol);
    int d;
    d = wrap16(act - exp);
    checks++;
    if (d > tol || d < -tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    prev_ideal = 0;
    pend_ovr = 1'b0;
    last_acc = -1000;
    check("reset_data", int'(bus.ast_source_data), 0, 0);
    check("reset_valid", int'(bus.ast_source_valid), 0, 0);
    check("reset_error", int'(bus.ast_source_error), 0, 0);
  endtask

  // Drive one sample; the model decides whether the DUT is free to take it
  task automatic send(int i, int q, logic [1:0] err);
    int   e;
    int   ph;
    bit   acc;
    exp_t x;
    @(negedge clk);
    e = cyc + 1;
    acc = (e >= last_acc + GAP_MIN);
    bus.ast_sink_i     = DW'(i);
    bus.ast_sink_q     = DW'(q);
    bus.ast_sink_valid = 1'b1;
    bus.ast_sink_error = acc ? err : 2'b00;
    if (acc) begin
      ph = ideal_phase(i, q);
      x.data = (ph - prev_ideal) & 32'hFFFF;
      x.err  = {|err, pend_ovr};
      x.cyc  = e + LAT;
      x.tol  = cur_tol;
      sb.push_back(x);
      prev_ideal = ph;
      pend_ovr = 1'b0;
      last_acc = e;
    end else if (e <= last_acc + ITER) begin
      if (sb.size() > 0) begin
        x = sb[sb.size()-1];
        x.err[0] = 1'b1;
        sb[sb.size()-1] = x;
      end
    end else begin
      pend_ovr = 1'b1;
    end
    @(negedge clk);
    bus.ast_sink_valid = 1'b0;
    bus.ast_sink_error = 2'b00;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_empty", sb.size(), 0, 0);
  endtask

  // Output monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus.ast_source_valid) begin
      n_out++;
      check("valid_not_back_to_back", int'(prev_valid), 0, 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: data=%0d err=%0d at cycle %0d, none expected",
                 bus.ast_source_data, bus.ast_source_error, cyc);
      end else begin
        e = sb.pop_front();
        check("out_data", int'(bus.ast_source_data), e.data, e.tol);
        check("out_error", int'(bus.ast_source_error), int'(e.err), 0);
        check("out_latency", cyc, e.cyc, 0);
      end
    end
    prev_valid = bus.ast_source_valid;
  end

  initial begin
    int n0;
    int ph0;
    int amp;
    int ang;
    bus.ast_sink_i     = '0;
    bus.ast_sink_q     = '0;
    bus.ast_sink_valid = 1'b0;
    bus.ast_sink_error = 2'b00;
    idle(3);
    do_reset();

    // Axis samples from a clean reset
    cur_tol = 6;
    send(16384, 0, 2'b00);
    idle(20);
    send(0, 16384, 2'b00);
    idle(20);
    drain();
    check("data_holds", int'(bus.ast_source_data), 16384, 6);

    // Unwrap across the negative real axis
    do_reset();
    send(-16384, 100, 2'b00);
    idle(20);
    send(-16384, -100, 2'b00);
    idle(20);
    drain();

    // Overrun: second sample five cycles later is dropped
    send(20000, 5000, 2'b00);
    idle(3);
    send(-3000, 20000, 2'b00);
    idle(30);
    send(10000, -15000, 2'b00);
    idle(20);
    drain();

    // Upstream error forwarded with one sample only
    send(12000, 12000, 2'b10);
    idle(20);
    send(-12000, 9000, 2'b00);
    idle(20);
    drain();

    // Reset at CORDIC iteration 7 discards the in-flight sample
    send(15000, 7000, 2'b00);
    idle(6);
    do_reset();
    n0 = n_out;
    idle(30);
    check("no_pulse_after_reset", n_out - n0, 0, 0);
    send(16384, 16384, 2'b00);
    idle(20);
    drain();

    // Rotating phasor, pi/8 per sample
    ph0 = int'($urandom_range(0, 65535));
    for (int s = 0; s < 32; s++) begin
      ang = (ph0 + s * 4096) & 32'hFFFF;
      send(int'(20000.0 * $cos(real'(ang) * PI / 32768.0)),
           int'(20000.0 * $sin(real'(ang) * PI / 32768.0)), 2'b00);
      idle(62);
    end
    drain();

    // Random samples, random spacing (some dropped), occasional upstream error
    cur_tol = 10;
    for (int s = 0; s < 60; s++) begin
      logic [1:0] er;
      amp = int'($urandom_range(12000, 30000));
      ang = int'($urandom_range(0, 65535));
      er  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send(int'(real'(amp) * $cos(real'(ang) * PI / 32768.0)),
           int'(real'(amp) * $sin(real'(ang) * PI / 32768.0)), er);
      idle(int'($urandom_range(0, 30)));
    end
    idle(20);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
